aes_dispatcher: RTL and testbench

AES_DISPATCHER -- requirements
Module: aes_dispatcher

---
 rtl/aes_dispatch_pkg.sv | 11 +
 rtl/aes_prio_pick.sv | 17 +
 rtl/aes_dispatcher.sv | 153 +++++++++++++++
 tb/tb_aes_dispatcher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dispatch_pkg.sv
// aes_dispatch_pkg: engine state, default block width and engine index type
// shared by the AES dispatcher files.
package aes_dispatch_pkg;
    localparam int DATA_W_DEF = 128;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_e;
    typedef logic [2:0] eng_idx_t;
endpackage

// File: rtl/aes_prio_pick.sv
// aes_prio_pick: returns the lowest set bit position of req and whether any bit is set.
module aes_prio_pick
    import aes_dispatch_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output eng_idx_t     idx,
    output logic         found
);
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[k]) idx = eng_idx_t'(k);
    end
    assign found = |req;
endmodule

// File: rtl/aes_dispatcher.sv
// aes_dispatcher: spreads AES blocks over NUM_ENG engines and returns their results.
// Define AES_DISPATCH_INORDER_EN to retire in accept order; otherwise the lowest-index DONE engine retires first.
module aes_dispatcher
    import aes_dispatch_pkg::*;
#(
    parameter int NUM_ENG = 3,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_encrypt,
    output logic [NUM_ENG-1:0]        eng_enable,
    output logic [NUM_ENG*DATA_W-1:0] eng_data,
    output logic [NUM_ENG-1:0]        eng_encrypt,
    input  logic [NUM_ENG-1:0]        eng_ready,
    input  logic [NUM_ENG*DATA_W-1:0] eng_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_encrypt,
    output logic                      busy_out
);
    eng_state_e st_q [NUM_ENG];
    eng_state_e st_d [NUM_ENG];
    logic [NUM_ENG-1:0][DATA_W-1:0] eng_data_q, eng_data_d, hold_q, hold_d;
    logic [NUM_ENG-1:0] eng_encrypt_q, eng_encrypt_d, idle_m;
    logic out_valid_q, out_valid_d, out_encrypt_q, out_encrypt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    eng_idx_t out_idx_q, out_idx_d, acc_idx, nxt_idx;
    logic acc_found, nxt_found, accept, retire, load;

    always_comb begin
        for (int k = 0; k < NUM_ENG; k++) begin
            idle_m[k] = st_q[k] == ST_IDLE;
            eng_enable[k] = st_q[k] == ST_RUN;
        end
    end

    aes_prio_pick #(.N(NUM_ENG)) u_idle_pick (.req(idle_m), .idx(acc_idx), .found(acc_found));

    assign busy_out = !acc_found;
    assign in_ready = !busy_out;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid_q && out_ready;
    assign load     = !out_valid_q || retire;

`ifdef AES_DISPATCH_INORDER_EN
    eng_idx_t q_q [NUM_ENG];
    eng_idx_t q_d [NUM_ENG];
    logic [3:0] cnt_q, cnt_d;
    logic nxt_done;
    // The presented engine is always the queue head, so the next candidate sits one slot behind it.
    always_comb begin
        q_d = q_q;
        cnt_d = cnt_q;
        if (retire) begin
            for (int k = 0; k < NUM_ENG - 1; k++) q_d[k] = q_q[k + 1];
            cnt_d = cnt_q - 4'd1;
        end
        if (accept) begin
            for (int k = 0; k < NUM_ENG; k++)
                if (4'(k) == cnt_d) q_d[k] = acc_idx;
            cnt_d = cnt_d + 4'd1;
        end
        nxt_idx = out_valid_q ? q_q[1] : q_q[0];
        nxt_done = 1'b0;
        for (int k = 0; k < NUM_ENG; k++)
            if (nxt_idx == eng_idx_t'(k)) nxt_done = st_q[k] == ST_DONE;
        nxt_found = (cnt_q > {3'b0, out_valid_q}) && nxt_done;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            q_q <= q_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic [NUM_ENG-1:0] cand_m;
    always_comb begin
        for (int k = 0; k < NUM_ENG; k++)
            cand_m[k] = st_q[k] == ST_DONE && !(out_valid_q && out_idx_q == eng_idx_t'(k));
    end
    aes_prio_pick #(.N(NUM_ENG)) u_done_pick (.req(cand_m), .idx(nxt_idx), .found(nxt_found));
`endif

    // Accept, completion and retire always hit engines in different states, so they never collide.
    always_comb begin
        st_d = st_q;
        eng_data_d = eng_data_q;
        eng_encrypt_d = eng_encrypt_q;
        hold_d = hold_q;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (accept && acc_idx == eng_idx_t'(k)) begin
                st_d[k] = ST_RUN;
                eng_data_d[k] = in_data;
                eng_encrypt_d[k] = in_encrypt;
            end
            if (st_q[k] == ST_RUN && eng_ready[k]) begin
                st_d[k] = ST_DONE;
                hold_d[k] = eng_result[k*DATA_W +: DATA_W];
            end
            if (retire && out_idx_q == eng_idx_t'(k)) st_d[k] = ST_IDLE;
        end
    end

    always_comb begin
        out_valid_d = load ? nxt_found : out_valid_q;
        out_idx_d = out_idx_q;
        out_data_d = out_data_q;
        out_encrypt_d = out_encrypt_q;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (load && nxt_found && nxt_idx == eng_idx_t'(k)) begin
                out_idx_d = nxt_idx;
                out_data_d = hold_q[k];
                out_encrypt_d = eng_encrypt_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '{default: ST_IDLE};
            eng_data_q <= '0;
            eng_encrypt_q <= '1;
            hold_q <= '0;
            out_valid_q <= 1'b0;
            out_idx_q <= '0;
            out_data_q <= '0;
            out_encrypt_q <= 1'b0;
        end else begin
            st_q <= st_d;
            eng_data_q <= eng_data_d;
            eng_encrypt_q <= eng_encrypt_d;
            hold_q <= hold_d;
            out_valid_q <= out_valid_d;
            out_idx_q <= out_idx_d;
            out_data_q <= out_data_d;
            out_encrypt_q <= out_encrypt_d;
        end
    end

    assign eng_data    = eng_data_q;
    assign eng_encrypt = eng_encrypt_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_encrypt = out_encrypt_q;
endmodule

// File: tb/tb_aes_dispatcher.sv
// tb_aes_dispatcher: directed stimulus with a scoreboard queue checked by a separate output monitor.
module tb_aes_dispatcher;
    localparam int N = 3;
    localparam int W = 128;
`ifdef AES_DISPATCH_INORDER_EN
    localparam logic [N-1:0] P39 = 3'b011, EN_A = 3'b100, EN_A2 = 3'b100, EN_A3 = 3'b101;
    localparam int D_ENG = 0;
`else
    localparam logic [N-1:0] P39 = 3'b010, EN_A = 3'b101, EN_A2 = 3'b101, EN_A3 = 3'b111;
    localparam int D_ENG = 1;
`endif
    localparam logic [W-1:0] A  = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [W-1:0] B  = 128'hfedc_ba98_7654_3210_aaaa_bbbb_cccc_dddd;
    localparam logic [W-1:0] C  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [W-1:0] D  = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
    localparam logic [W-1:0] RA = 128'ha0a0_a0a0_a0a0_a0a0_a0a0_a0a0_a0a0_a0a0;
    localparam logic [W-1:0] RB = 128'hb1b1_b1b1_b1b1_b1b1_b1b1_b1b1_b1b1_b1b1;
    localparam logic [W-1:0] RC = 128'hc2c2_c2c2_c2c2_c2c2_c2c2_c2c2_c2c2_c2c2;
    localparam logic [W-1:0] K  = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    typedef struct packed {
        logic [W-1:0] data;
        logic         enc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_encrypt = 1'b0;
    logic out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [N-1:0] eng_ready = '0;
    logic [N*W-1:0] eng_result = '0;
    logic [N-1:0] eng_enable, eng_encrypt;
    logic [N*W-1:0] eng_data;
    logic in_ready, out_valid, out_encrypt, busy_out;
    logic [W-1:0] out_data;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    logic hold_prev = 1'b0;
    logic [W-1:0] data_prev = '0;

    always #5 clk = ~clk;

    aes_dispatcher #(.NUM_ENG(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_encrypt(in_encrypt),
        .eng_enable(eng_enable), .eng_data(eng_data), .eng_encrypt(eng_encrypt),
        .eng_ready(eng_ready), .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_encrypt(out_encrypt),
        .busy_out(busy_out)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] d, input logic e);
        in_valid = 1'b1;
        in_data = d;
        in_encrypt = e;
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    always @(negedge clk) begin
        if (hold_prev) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_data", out_data, data_prev);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_encrypt", W'(out_encrypt), W'(mon_e.enc));
            end
        end
        hold_prev <= !rst && out_valid && !out_ready;
        data_prev <= out_data;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_busy", W'(busy_out), W'(0));
        chk("rst_enable", W'(eng_enable), W'(0));
        chk("rst_encrypt", W'(eng_encrypt), W'(3'b111));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_eng_data", W'(|eng_data), W'(0));

        // three back-to-back accepts, fourth block held
        offer(A, 1'b1);
        tick();
        chk("acc1_enable", W'(eng_enable), W'(3'b001));
        chk("acc1_in_ready", W'(in_ready), W'(1));
        offer(B, 1'b0);
        tick();
        chk("acc2_enable", W'(eng_enable), W'(3'b011));
        offer(C, 1'b1);
        tick();
        chk("acc3_enable", W'(eng_enable), W'(3'b111));
        chk("acc3_busy", W'(busy_out), W'(1));
        chk("acc3_in_ready", W'(in_ready), W'(0));
        chk("acc3_data0", eng_data[0 +: W], A);
        chk("acc3_data1", eng_data[W +: W], B);
        chk("acc3_data2", eng_data[2*W +: W], C);
        chk("acc3_encrypt", W'(eng_encrypt), W'(3'b101));
        offer(D, 1'b0);
        tick();
        chk("full_in_ready", W'(in_ready), W'(0));
        chk("full_enable", W'(eng_enable), W'(3'b111));

        // engine 1 finishes while block D waits
        eng_result[0 +: W] = RA;
        eng_result[W +: W] = RB;
        eng_ready = P39;
        if (P39[0]) sb.push_back('{data: RA, enc: 1'b1});
        sb.push_back('{data: RB, enc: 1'b0});
        tick();
        eng_ready = '0;
        chk("done_enable", W'(eng_enable), W'(EN_A));
        chk("lat1_out_valid", W'(out_valid), W'(0));
        tick();
        chk("lat2_out_valid", W'(out_valid), W'(1));
        chk("lat2_in_ready", W'(in_ready), W'(0));
        tick();
        chk("freed_in_ready", W'(in_ready), W'(1));
        chk("freed_enable", W'(eng_enable), W'(EN_A2));
        tick();
        in_valid = 1'b0;
        chk("redisp_enable", W'(eng_enable), W'(EN_A3));
        chk("redisp_data", eng_data[D_ENG*W +: W], D);
        chk("redisp_encrypt", W'(eng_encrypt[D_ENG]), W'(0));

        // output stall with out_ready low
        out_ready = 1'b0;
        eng_result[2*W +: W] = K;
        eng_ready = 3'b100;
        sb.push_back('{data: K, enc: 1'b1});
        tick();
        eng_ready = '0;
        chk("stall_lat1", W'(out_valid), W'(0));
        tick();
        chk("stall_valid", W'(out_valid), W'(1));
        chk("stall_data", out_data, K);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_valid", W'(out_valid), W'(1));
            chk("stall_hold_data", out_data, K);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_retired", W'(out_valid), W'(0));

        // fill to two RUN plus one DONE, then reset mid-operation
        out_ready = 1'b0;
        offer(C, 1'b0);
        for (int i = 0; i < 4 && !busy_out; i++) tick();
        in_valid = 1'b0;
        chk("pre_rst_busy", W'(busy_out), W'(1));
        eng_ready = 3'b001;
        tick();
        eng_ready = '0;
        tick();
        chk("pre_rst_valid", W'(out_valid), W'(1));
        chk("pre_rst_enable", W'(eng_enable), W'(3'b110));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_enable", W'(eng_enable), W'(0));
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_encrypt", W'(eng_encrypt), W'(3'b111));
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        eng_ready = 3'b111;
        tick();
        eng_ready = '0;
        tick();
        chk("idle_ready_ignored", W'(out_valid), W'(0));
        chk("idle_ready_enable", W'(eng_enable), W'(0));

        // engines finish C, A, B
`ifdef AES_DISPATCH_INORDER_EN
        sb.push_back('{data: RA, enc: 1'b1});
        sb.push_back('{data: RB, enc: 1'b0});
        sb.push_back('{data: RC, enc: 1'b1});
`else
        sb.push_back('{data: RC, enc: 1'b1});
        sb.push_back('{data: RA, enc: 1'b1});
        sb.push_back('{data: RB, enc: 1'b0});
`endif
        offer(A, 1'b1);
        tick();
        offer(B, 1'b0);
        tick();
        offer(C, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ord_enable", W'(eng_enable), W'(3'b111));
        eng_result = {RC, RB, RA};
        eng_ready = 3'b100;
        tick();
        eng_ready = 3'b001;
        tick();
        eng_ready = 3'b010;
        tick();
        eng_ready = '0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drain_left", W'(sb.size()), W'(0));
        tick();
        chk("final_in_ready", W'(in_ready), W'(1));
        chk("final_out_valid", W'(out_valid), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
